alu_multicycle_unit: RTL and testbench
======================================

Name: alu_multicycle_unit

Overview:
Parametrised successor to the single-cycle ALU with a registered valid/ready issue interface.
- Accepts one ALU-class instruction per handshake and latches its operands.
- Executes simple ops in 1 cycle and MUL on an iterative shift-add sub-unit.
- Returns a single write-back request to the GPR file, with full Z/N/C/V status flags. Sits between instruction dispatch and the GPR file.

Parameters:
WIDTH, 32, datapath and GPR width (8..64)
NUM_GPR, 16, number of GPRs; register fields are 4 bits, so NUM_GPR must be at most 16
IMM_SEXT, 1, 1 = sign-extend the 32-bit immediate to WIDTH, 0 = zero-extend

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  dispatch presents inst
in_ready  out  1  unit can accept (state IDLE)
inst  in  48  instruction word
gpr_rd  in  NUM_GPR x WIDTH  current GPR contents
wb_valid  out  1  one-cycle completion pulse
wb_we  out  1  write-back requested (valid only with wb_valid)
wb_addr  out  4  destination GPR
wb_data  out  WIDTH  result
illegal  out  1  one-cycle pulse with wb_valid: bad class or opcode
busy  out  1  state != IDLE
status  out  8  {4'b0, V, C, N, Z}

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset: state IDLE, in_ready=1, busy=0, wb_valid=0, wb_we=0, wb_addr=0, wb_data=0, illegal=0, status=0.
- Reset mid-operation aborts the op: no write-back and no flag update.
- Decode fields: class inst[2:0] (ALU = 3'b100); imm flag inst[3]; opcode inst[7:4]; rA inst[11:8]; rB inst[15:12]; imm inst[47:16].
- Register mode (inst[3]=0): op_a=gpr[rA], op_b=gpr[rB], dest=rB.
- Immediate mode (inst[3]=1): op_a=ext(imm), op_b=gpr[rA], dest=rA.
- Register indices at or above NUM_GPR are illegal.
- Handshake: transfer when in_valid && in_ready.
  - inst and both operands are latched in that cycle; later gpr_rd changes have no effect.
  - in_ready=0 from the cycle after acceptance until the cycle after the wb_valid pulse.
- Opcodes (unlisted = illegal):
  - 1000 ADD a+b
  - 0010 SUB b-a
  - 1100 AND
  - 0100 IOR
  - 1010 XOR
  - 0110 NOT ~a
  - 1110 MUL low WIDTH bits of a*b
  - 0001 MOV a
  - 1001 CMP b-a, no write
  - 0101 LSL a<<1
  - 1101 LSR a>>1 (logical)
  - 0011 ASR a>>>1
- FSM:
  - IDLE -> EXEC on accept of a non-MUL op or an illegal inst.
  - IDLE -> MUL on accept of MUL.
  - EXEC -> IDLE: drives the registered wb_* for one cycle.
  - MUL: counts WIDTH iterations, then -> IDLE with wb_valid.
- Latency, counted from the accept edge N:
  - Simple/illegal: wb_valid high in cycle N+1.
  - MUL: wb_valid high in cycle N+WIDTH+1.
  - Back-to-back accept is possible in the cycle after wb_valid.
- wb_we: 1 for all legal ops except CMP; 0 for CMP and for illegal.
- Flags: updated in the wb_valid cycle; visible on status from the next cycle.
  - ADD/SUB/CMP: Z, N = MSB, C (ADD carry-out; SUB/CMP = no-borrow, i.e. b>=a unsigned), V (signed overflow).
  - Logic/MOV/NOT: Z and N only; C and V hold.
  - Shifts: Z, N, C = bit shifted out; V holds.
  - MUL: Z, N, C=V=(upper WIDTH bits of the full product != 0).
  - Illegal: flags unchanged.
- No back-pressure on wb: the GPR file always accepts.
- in_valid while busy is ignored and is not queued.

Decomposition:
- Package alu_pkg: opcode enum alu_op_e, class constant ALU_CLASS=3'b100, flag bit indices FLAG_Z/N/C/V, fsm enum alu_state_e.
- Sub-module alu_seq_multiplier(WIDTH):
  - Ports: start, a, b, done, prod[2*WIDTH-1:0].
  - Radix-2 shift-add, WIDTH cycles, async reset.

Test Plan:
1. Register ADD: gpr[1]=5, gpr[2]=7, inst rA=1 rB=2 op=1000 -> wb at N+1, wb_addr=2, wb_data=12, wb_we=1; next cycle status=0.
2. Immediate SUB underflow: imm=3, gpr[4]=2 -> wb_data=32'hFFFFFFFF, wb_addr=4; status N=1, C=0, Z=0, V=0.
3. MUL: 32'h0001_0000 * 32'h0001_0000 -> wb_valid exactly at N+33, wb_data=0, Z=1, C=V=1; in_ready=0 throughout the op; a second in_valid during MUL is dropped.
4. CMP equal: 9 vs 9 -> wb_valid=1, wb_we=0, Z=1, C=1; the GPR is not written.
5. Illegal: opcode 0111, and separately class 3'b010 -> illegal=1, wb_we=0, status unchanged.
6. Reset asserted 10 cycles into a MUL -> all outputs return to their reset values immediately; no wb_valid follows; in_ready=1 after rst is deasserted.

Source files
------------

// File: rtl/alu_multicycle_unit_pkg.sv
// Shared opcode, state and flag definitions for the multicycle ALU.
package alu_pkg;

  localparam logic [2:0] ALU_CLASS = 3'b100;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [3:0] {
    OP_ADD = 4'b1000,
    OP_SUB = 4'b0010,
    OP_AND = 4'b1100,
    OP_IOR = 4'b0100,
    OP_XOR = 4'b1010,
    OP_NOT = 4'b0110,
    OP_MUL = 4'b1110,
    OP_MOV = 4'b0001,
    OP_CMP = 4'b1001,
    OP_LSL = 4'b0101,
    OP_LSR = 4'b1101,
    OP_ASR = 4'b0011
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL
  } alu_state_e;

endpackage

// File: rtl/alu_multicycle_unit_if.sv
// Issue and write-back bundle between dispatch, the ALU unit and the GPR file.
interface alu_multicycle_unit_if #(parameter int WIDTH = 32);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [47:0]      inst;
  logic             wb_valid;
  logic             wb_we;
  logic [3:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             illegal;

  modport master (
    output in_valid, inst,
    input  in_ready, wb_valid, wb_we, wb_addr, wb_data, illegal
  );

  modport slave (
    input  in_valid, inst,
    output in_ready, wb_valid, wb_we, wb_addr, wb_data, illegal
  );
endinterface

// File: rtl/alu_multicycle_unit_seq_multiplier.sv
// Radix-2 shift-add multiplier: operands latched on start, WIDTH iterations, then a done pulse.
module alu_seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               running;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= '0;
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
        count   <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign prod = acc;

endmodule

// File: rtl/alu_multicycle_unit.sv
// ALU issue unit: latches one instruction per handshake, returns a single GPR write-back with flags.
module alu_multicycle_unit
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_GPR  = 16,
  parameter int IMM_SEXT = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  alu_multicycle_unit_if.slave            bus,
  input  logic [NUM_GPR-1:0][WIDTH-1:0]   gpr_rd,
  output logic                            busy,
  output logic [7:0]                      status
);

  localparam int MSB = WIDTH - 1;
  localparam int IW  = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

  alu_state_e state_q, state_d;

  logic [2:0]       cls;
  logic             imm_mode;
  alu_op_e          opc;
  logic [3:0]       ra, rb, dest;
  logic [31:0]      imm;
  logic [63:0]      imm64;
  logic [WIDTH-1:0] ra_val, rb_val, op_a, op_b;
  logic             op_known, idx_bad, dec_illegal, dec_mul, accept;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res;
  logic [3:0]       flags_d, mul_flags, wb_flags;

  logic             wb_we_q, illegal_q;
  logic [3:0]       wb_addr_q;
  logic [WIDTH-1:0] wb_data_q;
  logic [3:0]       flags_q;
  logic [7:0]       status_q;

  logic             in_ready, wb_valid, wb_we, illegal, status_load;
  logic [3:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;

  logic             mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  always_comb begin
    cls      = bus.inst[2:0];
    imm_mode = bus.inst[3];
    opc      = alu_op_e'(bus.inst[7:4]);
    ra       = bus.inst[11:8];
    rb       = bus.inst[15:12];
    imm      = bus.inst[47:16];
    imm64    = (IMM_SEXT != 0) ? {{32{imm[31]}}, imm} : {32'b0, imm};

    ra_val = '0;
    rb_val = '0;
    for (int unsigned i = 0; i < NUM_GPR; i++) begin
      if (ra == 4'(i)) ra_val = gpr_rd[IW'(i)];
      if (rb == 4'(i)) rb_val = gpr_rd[IW'(i)];
    end

    op_a = imm_mode ? imm64[WIDTH-1:0] : ra_val;
    op_b = imm_mode ? ra_val : rb_val;
    dest = imm_mode ? ra : rb;

    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_IOR, OP_XOR, OP_NOT,
      OP_MUL, OP_MOV, OP_CMP, OP_LSL, OP_LSR, OP_ASR: op_known = 1'b1;
      default:                                        op_known = 1'b0;
    endcase

    // rB only names a register in register mode
    idx_bad     = (int'(ra) >= NUM_GPR) || (!imm_mode && (int'(rb) >= NUM_GPR));
    dec_illegal = (cls != ALU_CLASS) || !op_known || idx_bad;
    dec_mul     = !dec_illegal && (opc == OP_MUL);
  end

  assign accept = (state_q == S_IDLE) && bus.in_valid;

  always_comb begin
    sum     = {1'b0, op_a} + {1'b0, op_b};
    diff    = {1'b0, op_b} - {1'b0, op_a};
    res     = '0;
    flags_d = status_q[3:0];
    case (opc)
      OP_ADD: begin
        res             = sum[WIDTH-1:0];
        flags_d[FLAG_C] = sum[WIDTH];
        flags_d[FLAG_V] = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res             = diff[WIDTH-1:0];
        flags_d[FLAG_C] = ~diff[WIDTH];
        flags_d[FLAG_V] = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_b[MSB]);
      end
      OP_AND: res = op_a & op_b;
      OP_IOR: res = op_a | op_b;
      OP_XOR: res = op_a ^ op_b;
      OP_NOT: res = ~op_a;
      OP_MOV: res = op_a;
      OP_LSL: begin
        res             = {op_a[WIDTH-2:0], 1'b0};
        flags_d[FLAG_C] = op_a[MSB];
      end
      OP_LSR: begin
        res             = {1'b0, op_a[WIDTH-1:1]};
        flags_d[FLAG_C] = op_a[0];
      end
      OP_ASR: begin
        res             = {op_a[MSB], op_a[WIDTH-1:1]};
        flags_d[FLAG_C] = op_a[0];
      end
      default: ;
    endcase
    flags_d[FLAG_Z] = (res == '0);
    flags_d[FLAG_N] = res[MSB];
    if (dec_illegal) begin
      res     = '0;
      flags_d = status_q[3:0];
    end
  end

  alu_seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept && dec_mul),
    .a     (op_a),
    .b     (op_b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
    mul_flags[FLAG_N] = mul_prod[MSB];
    mul_flags[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_V] = |mul_prod[2*WIDTH-1:WIDTH];
  end

  // Simple ops compute at accept; the registered result is presented while in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
      flags_q   <= '0;
      status_q  <= '0;
    end else begin
      if (accept) begin
        wb_we_q   <= !dec_illegal && (opc != OP_CMP);
        wb_addr_q <= dest;
        wb_data_q <= res;
        illegal_q <= dec_illegal;
        flags_q   <= flags_d;
      end
      if (status_load) status_q <= {4'b0, wb_flags};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    busy        = 1'b1;
    wb_valid    = 1'b0;
    wb_we       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    illegal     = 1'b0;
    status_load = 1'b0;
    wb_flags    = flags_q;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (bus.in_valid) state_d = dec_mul ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        wb_valid    = 1'b1;
        wb_we       = wb_we_q;
        wb_addr     = wb_addr_q;
        wb_data     = wb_data_q;
        illegal     = illegal_q;
        status_load = 1'b1;
        state_d     = S_IDLE;
      end
      S_MUL: begin
        if (mul_done) begin
          wb_valid    = 1'b1;
          wb_we       = 1'b1;
          wb_addr     = wb_addr_q;
          wb_data     = mul_prod[WIDTH-1:0];
          wb_flags    = mul_flags;
          status_load = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.wb_valid = wb_valid;
  assign bus.wb_we    = wb_we;
  assign bus.wb_addr  = wb_addr;
  assign bus.wb_data  = wb_data;
  assign bus.illegal  = illegal;
  assign status       = status_q;

endmodule

// File: tb/tb_alu_multicycle_unit.sv
// Scoreboard bench for alu_multicycle_unit: directed cases plus random instructions vs an arithmetic model.
module tb_alu_multicycle_unit;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        ill;
    logic [7:0]  st;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0][31:0] gpr;
  logic busy;
  logic [7:0] status;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t q[$];
  logic [7:0] mstat = 8'h00;
  logic st_pending = 1'b0;
  logic [7:0] st_exp = 8'h00;

  alu_multicycle_unit_if #(.WIDTH(32)) bus();

  alu_multicycle_unit #(.WIDTH(32), .NUM_GPR(16), .IMM_SEXT(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .gpr_rd (gpr),
    .busy   (busy),
    .status (status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic [31:0] imm, input logic [3:0] rb, input logic [3:0] ra,
                                     input logic [3:0] op, input logic immf, input logic [2:0] cls);
    return {imm, rb, ra, op, immf, cls};
  endfunction

  // Reference model: plain wide arithmetic on the architectural operands.
  function automatic exp_t model(input logic [47:0] i, input logic [7:0] s);
    exp_t e;
    logic [31:0] a, b, r;
    longint unsigned ua, ub, p;
    longint sa, sb, sr;
    logic c, v, legal;
    logic [3:0] op;
    op = i[7:4];
    if (i[3]) begin a = i[47:16]; b = gpr[i[11:8]]; e.addr = i[11:8]; end
    else      begin a = gpr[i[11:8]]; b = gpr[i[15:12]]; e.addr = i[15:12]; end
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = s[2]; v = s[3]; r = 32'h0; p = 0; sr = 0;
    legal = (i[2:0] == 3'b100);
    case (op)
      4'b1000: begin p = ua + ub; r = p[31:0]; c = (p >> 32) != 0;
                     sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
      4'b0010, 4'b1001: begin r = b - a; c = (ub >= ua);
                     sr = sb - sa; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
      4'b1100: r = a & b;
      4'b0100: r = a | b;
      4'b1010: r = a ^ b;
      4'b0110: r = ~a;
      4'b0001: r = a;
      4'b1110: begin p = ua * ub; r = p[31:0]; c = (p >> 32) != 0; v = c; end
      4'b0101: begin r = a << 1; c = a[31]; end
      4'b1101: begin r = a >> 1; c = a[0]; end
      4'b0011: begin r = (a >> 1) | (a & 32'h8000_0000); c = a[0]; end
      default: legal = 1'b0;
    endcase
    e.ill  = !legal;
    e.we   = legal && (op != 4'b1001);
    e.data = r;
    e.st   = legal ? {4'b0, v, c, r[31], (r == 32'h0)} : s;
    e.lat  = (legal && op == 4'b1110) ? 33 : 1;
    e.acc  = 0;
    return e;
  endfunction

  task automatic rand_gpr();
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 5))
        0: gpr[k] = 32'h0;
        1: gpr[k] = 32'h7FFF_FFFF;
        2: gpr[k] = 32'h8000_0000;
        3: gpr[k] = 32'hFFFF_FFFF;
        4: gpr[k] = 32'($urandom_range(0, 20));
        default: gpr[k] = $urandom;
      endcase
    end
  endtask

  task automatic issue(input logic [47:0] i);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      chk("in_ready_wait", bus.in_ready, 1);
      return;
    end
    #2;
    bus.inst = i;
    bus.in_valid = 1'b1;
    e = model(i, mstat);
    e.acc = cyc;
    @(posedge clk);
    q.push_back(e);
    mstat = e.st;
    #1;
    bus.in_valid = 1'b0;
    rand_gpr();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      st_pending = 1'b0;
    end else begin
      if (st_pending) begin
        chk("status", status, st_exp);
        st_pending = 1'b0;
      end
      chk("busy", busy, q.size() != 0);
      chk("in_ready", bus.in_ready, q.size() == 0);
      if (bus.wb_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got wb_valid=1 addr=%0h data=%0h expected no write-back",
                   bus.wb_addr, bus.wb_data);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - e.acc, e.lat);
          chk("illegal", bus.illegal, e.ill);
          chk("wb_we", bus.wb_we, e.we);
          if (!e.ill) begin
            chk("wb_addr", bus.wb_addr, e.addr);
            chk("wb_data", bus.wb_data, e.data);
          end
          st_pending = 1'b1;
          st_exp = e.st;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.inst = '0;
    gpr = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_we", bus.wb_we, 0);
    chk("rst_wb_addr", bus.wb_addr, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_status", status, 0);
    #2 rst = 1'b0;

    // 1: register ADD
    gpr[1] = 32'd5; gpr[2] = 32'd7;
    issue(mk(32'h0, 4'd2, 4'd1, 4'b1000, 1'b0, 3'b100));
    // 2: immediate SUB underflow
    gpr[4] = 32'd2;
    issue(mk(32'd3, 4'd0, 4'd4, 4'b0010, 1'b1, 3'b100));
    // 3: MUL with overflow into upper half, plus ignored in_valid while busy
    gpr[1] = 32'h0001_0000; gpr[2] = 32'h0001_0000;
    issue(mk(32'h0, 4'd2, 4'd1, 4'b1110, 1'b0, 3'b100));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2 bus.in_valid = 1'b1;
      bus.inst = mk(32'h0, 4'd3, 4'd5, 4'b1000, 1'b0, 3'b100);
    end
    @(negedge clk);
    #2 bus.in_valid = 1'b0;
    // 4: CMP equal
    gpr[3] = 32'd9; gpr[5] = 32'd9;
    issue(mk(32'h0, 4'd5, 4'd3, 4'b1001, 1'b0, 3'b100));
    // 5: illegal opcode and illegal class
    issue(mk(32'h0, 4'd5, 4'd3, 4'b0111, 1'b0, 3'b100));
    issue(mk(32'h0, 4'd5, 4'd3, 4'b1000, 1'b0, 3'b010));
    // negative immediate exercises sign extension
    issue(mk(32'hFFFF_FFF0, 4'd0, 4'd6, 4'b1000, 1'b1, 3'b100));

    for (int k = 0; k < 80; k++) begin
      logic [47:0] i;
      i = {32'($urandom), 16'($urandom)};
      i[2:0] = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b100;
      if ($urandom_range(0, 1) == 1) i[47:16] = 32'($urandom_range(0, 15));
      issue(i);
    end

    // 6: reset in the middle of a MUL
    issue(mk(32'h0, 4'd2, 4'd1, 4'b1110, 1'b0, 3'b100));
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wb_valid", bus.wb_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_status", status, 0);
    chk("midrst_wb_data", bus.wb_data, 0);
    chk("midrst_illegal", bus.illegal, 0);
    q.delete();
    mstat = 8'h00;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    #1 chk("post_rst_in_ready", bus.in_ready, 1);
    gpr[7] = 32'h8000_0001;
    issue(mk(32'h0, 4'd0, 4'd7, 4'b0011, 1'b1, 3'b100));

    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain_pending", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
